// File: rtl/regfile_writeback_controller_pkg.sv
// Shared types and constants for the register-file writeback path.
// Latency: none (types only).
// Backpressure: not applicable.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int WB_DATA_W  = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = 5'd0;

  // One writeback as seen by the register file at the default data width
  typedef struct packed {
    reg_addr_t             register;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_writeback_controller_if.sv
// Writeback request bundle from N requesters toward the controller.
// Latency: none (wires only).
// Backpressure: per-requester ready returned by the controller.
interface regfile_writeback_controller_if
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32
) ();

  logic      [NUM_REQ-1:0]             req_valid;
  logic      [NUM_REQ-1:0]             req_ready;
  reg_addr_t [NUM_REQ-1:0]             req_register;
  logic      [NUM_REQ-1:0][DATA_W-1:0] req_data;

  modport master (
    output req_valid,
    output req_register,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_register,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/regfile_writeback_controller_rr_arbiter.sv
// Round-robin arbiter; search starts one past the last granted index.
// Latency: grant is combinational; priority pointer moves at the next edge.
// Backpressure: pointer only advances when the caller reports a transfer.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] winner;
  logic             found;

  // Pick the first requesting index after last_grant, wrapping around
  always_comb begin
    grant  = '0;
    winner = last_grant;
    found  = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      int idx;
      idx = (int'(last_grant) + off) % NUM_REQ;
      if (!found && req[IDX_W'(idx)]) begin
        grant[IDX_W'(idx)] = 1'b1;
        winner             = IDX_W'(idx);
        found              = 1'b1;
      end
    end
  end

  // Reset points at the highest index so requester 0 wins first
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= IDX_W'(NUM_REQ - 1);
    end else if (advance && found) begin
      last_grant <= winner;
    end
  end

endmodule

// File: rtl/regfile_writeback_controller.sv
// Arbitrates N writeback requesters onto the single register-file write port and tracks pending writes.
// Latency: handshake in cycle t drives write_enable in t+1; busy drops in t+2.
// Backpressure: none from the register file; losers of arbitration see ready low.
module regfile_writeback_controller
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32
) (
  input  logic                           clock,
  input  logic                           reset_n,
  regfile_writeback_controller_if.slave  req,
  input  logic                           issue_valid,
  input  reg_addr_t                      issue_register,
  input  reg_addr_t                      query_register_1,
  input  reg_addr_t                      query_register_2,
  output logic                           query_busy_1,
  output logic                           query_busy_2,
  output logic                           write_enable,
  output reg_addr_t                      write_register,
  output logic [DATA_W-1:0]              write_data
);

  logic [NUM_REQ-1:0]  grant;
  logic                transfer;
  reg_addr_t           sel_register;
  logic [DATA_W-1:0]   sel_data;
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_next;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (req.req_valid),
    .advance (transfer),
    .grant   (grant)
  );

  // No requester may be granted while the block is held in reset
  assign req.req_ready = grant & {NUM_REQ{reset_n}};
  assign transfer      = |req.req_ready;

  // Route the granted requester's register and data to the output stage
  always_comb begin
    sel_register = ZERO_REG;
    sel_data     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_register = req.req_register[i];
        sel_data     = req.req_data[i];
      end
    end
  end

  // Output stage: x0 writes are accepted but never reach the register file
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      write_enable   <= 1'b0;
      write_register <= ZERO_REG;
      write_data     <= '0;
    end else begin
      write_enable <= transfer && (sel_register != ZERO_REG);
      if (transfer) begin
        write_register <= sel_register;
        write_data     <= sel_data;
      end
    end
  end

  // Scoreboard update: clear on commit first, so a same-edge issue wins
  always_comb begin
    pending_next = pending;
    if (write_enable) begin
      pending_next[write_register] = 1'b0;
    end
    if (issue_valid && (issue_register != ZERO_REG)) begin
      pending_next[issue_register] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  // No bypass: a write committing at the coming edge still reads busy now
  assign query_busy_1 = pending[query_register_1];
  assign query_busy_2 = pending[query_register_2];

endmodule

// File: tb/tb_regfile_writeback_controller.sv
module tb_regfile_writeback_controller;
  import regfile_pkg::*;

  localparam int N  = 2;
  localparam int DW = 32;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  regfile_writeback_controller_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

  logic          issue_valid;
  reg_addr_t     issue_register;
  reg_addr_t     q1, q2;
  logic          busy1, busy2;
  logic          we;
  reg_addr_t     wreg;
  logic [DW-1:0] wdata;

  regfile_writeback_controller #(.NUM_REQ(N), .DATA_W(DW)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .req              (bus),
    .issue_valid      (issue_valid),
    .issue_register   (issue_register),
    .query_register_1 (q1),
    .query_register_2 (q2),
    .query_busy_1     (busy1),
    .query_busy_2     (busy2),
    .write_enable     (we),
    .write_register   (wreg),
    .write_data       (wdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            m_lg    = N - 1;
  logic          m_we    = 1'b0;
  reg_addr_t     m_wreg  = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [31:0]   m_pend  = '0;
  logic [N-1:0]  m_g;
  logic [N-1:0]  exp_ready;

  // Round-robin rule: first valid requester after the last winner
  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v, input int lg);
    logic [N-1:0] one;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (lg + k) % N;
      if (v[j]) begin
        one = '0;
        one[j] = 1'b1;
        return one;
      end
    end
    return '0;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_lg = N - 1; m_we = 1'b0; m_wreg = '0; m_wdata = '0; m_pend = '0;
    end else begin
      m_g = rr_pick(bus.req_valid, m_lg);
      if (m_we) m_pend[m_wreg] = 1'b0;
      if (issue_valid && issue_register != 0) m_pend[issue_register] = 1'b1;
      m_we = 1'b0;
      for (int j = 0; j < N; j++) begin
        if (m_g[j]) begin
          m_lg    = j;
          m_we    = (bus.req_register[j] != 0);
          m_wreg  = bus.req_register[j];
          m_wdata = bus.req_data[j];
        end
      end
    end
  end

  always @(negedge clock) begin
    exp_ready = reset_n ? rr_pick(bus.req_valid, m_lg) : '0;
    check("model_ready", bus.req_ready, exp_ready);
    check("model_we", we, m_we);
    check("model_busy1", busy1, m_pend[q1]);
    check("model_busy2", busy2, m_pend[q2]);
    if (m_we) begin
      check("model_wreg", wreg, m_wreg);
      check("model_wdata", wdata, m_wdata);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [N-1:0] seq [4];

  initial begin
    bus.req_valid    = '0;
    bus.req_register = '0;
    bus.req_data     = '0;
    issue_valid      = 1'b0;
    issue_register   = '0;
    q1 = '0;
    q2 = '0;

    #1 reset_n = 1'b0;
    bus.req_valid = 2'b11;
    #2 check("ready_in_reset", bus.req_ready, 2'b00);
    bus.req_valid = 2'b00;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    #1;
    check("rst_we", we, 1'b0);
    check("rst_wreg", wreg, 5'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_ready", bus.req_ready, 2'b00);
    tick();

    for (int i = 0; i < 16; i++) begin
      q1 = 5'(i);
      q2 = 5'(i + 16);
      #1;
      check("rst_busy_lo", busy1, 1'b0);
      check("rst_busy_hi", busy2, 1'b0);
      tick();
    end

    // Both requesters valid: alternate starting from requester 0
    seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01; seq[3] = 2'b10;
    bus.req_register[0] = 5'd1; bus.req_data[0] = 32'h11;
    bus.req_register[1] = 5'd2; bus.req_data[1] = 32'h22;
    bus.req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1 check("rr_alternate", bus.req_ready, seq[k]);
      tick();
    end
    bus.req_valid = 2'b10;
    for (int k = 0; k < 3; k++) begin
      #1 check("rr_single", bus.req_ready, 2'b10);
      tick();
    end
    bus.req_valid = 2'b00;

    // Single write through requester 0
    bus.req_register[0] = 5'd5; bus.req_data[0] = 32'hDEADBEEF;
    bus.req_valid = 2'b01;
    #1 check("wb5_ready", bus.req_ready, 2'b01);
    tick();
    bus.req_valid = 2'b00;
    #1;
    check("wb5_we", we, 1'b1);
    check("wb5_reg", wreg, 5'd5);
    check("wb5_data", wdata, 32'hDEADBEEF);
    tick();
    #1 check("wb5_we_drop", we, 1'b0);

    // Issue to 7, writeback handshaken two cycles later
    issue_valid = 1'b1; issue_register = 5'd7; q1 = 5'd7;
    tick();
    issue_valid = 1'b0;
    #1 check("busy7_t1", busy1, 1'b1);
    tick();
    bus.req_register[1] = 5'd7; bus.req_data[1] = 32'h77;
    bus.req_valid = 2'b10;
    #1 check("busy7_t2", busy1, 1'b1);
    check("wb7_ready", bus.req_ready, 2'b10);
    tick();
    bus.req_valid = 2'b00;
    #1 check("busy7_t3", busy1, 1'b1);
    check("wb7_we", we, 1'b1);
    check("wb7_reg", wreg, 5'd7);
    tick();
    #1 check("busy7_t4", busy1, 1'b0);

    // Re-issue to 7 on the same edge its write commits keeps it pending
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
    bus.req_data[1] = 32'h78;
    bus.req_valid = 2'b10;
    tick();
    bus.req_valid = 2'b00;
    issue_valid = 1'b1;
    #1 check("waw_we", we, 1'b1);
    tick();
    issue_valid = 1'b0;
    #1 check("waw_keep", busy1, 1'b1);
    tick();
    #1 check("waw_keep2", busy1, 1'b1);

    // Writeback and issue to x0
    bus.req_register[0] = 5'd0; bus.req_data[0] = 32'h1234;
    bus.req_valid = 2'b01;
    issue_valid = 1'b1; issue_register = 5'd0; q1 = 5'd0;
    #1 check("x0_ready", bus.req_ready, 2'b01);
    tick();
    bus.req_valid = 2'b00;
    issue_valid = 1'b0;
    #1 check("x0_we", we, 1'b0);
    check("x0_busy", busy1, 1'b0);
    tick();

    // Asynchronous reset with a write in flight and three pending bits
    issue_valid = 1'b1; issue_register = 5'd3;
    tick();
    issue_register = 5'd9;
    tick();
    issue_valid = 1'b0;
    bus.req_register[0] = 5'd12; bus.req_data[0] = 32'hABCD;
    bus.req_valid = 2'b01;
    tick();
    bus.req_valid = 2'b00;
    q1 = 5'd3; q2 = 5'd9;
    #1;
    check("pre_rst_we", we, 1'b1);
    check("pre_rst_busy3", busy1, 1'b1);
    check("pre_rst_busy9", busy2, 1'b1);
    reset_n = 1'b0;
    #1;
    check("arst_we", we, 1'b0);
    check("arst_wreg", wreg, 5'd0);
    check("arst_busy3", busy1, 1'b0);
    check("arst_busy9", busy2, 1'b0);
    q1 = 5'd7;
    #1 check("arst_busy7", busy1, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
